usb_ep_rx_drain_arbiter: RTL and testbench
==========================================

# usb_ep_rx_drain_arbiter

Application-side scheduler that drains received host-OUT packets from the device-IN FIFOs of endpoints EP01..EPn into one shared byte stream. It grants one endpoint at a time in round-robin order and streams that endpoint's whole transaction through a valid/ready port tagged with endpoint index and last-byte flag. It then commits the transaction back to the endpoint, or rolls it back on abort. It connects to the `EP_IN_pop*` / `EP_IN_dataAvailable` / `EP_IN_data` ports of the endpoint arbiter.

## Interface
- `EP_COUNT`, default 2: number of non-control endpoints served (index 0 = EP01); 1..15.
- `MAX_PKT_BYTES`, default 64: maximum bytes streamed per grant; 1..1023.
- `EP_IDX_WID`, localparam: `max(1, $clog2(EP_COUNT))`.

Ports:
- `clk12_i`, in, 1: 12 MHz clock; all state on rising edge.
- `rstn_i`, in, 1: reset, asynchronous and active-low; one clock, async active-low reset.
- `EP_IN_dataAvailable_i`, in, EP_COUNT: per-endpoint FIFO has a committed byte at its head.
- `EP_IN_data_i`, in, 8*EP_COUNT: per-endpoint head byte (first-word fall-through), `[k*8 +: 8]`.
- `EP_IN_popData_o`, out, EP_COUNT: pop head byte of endpoint k.
- `EP_IN_popTransDone_o`, out, EP_COUNT: 1-cycle pulse that ends the read transaction.
- `EP_IN_popTransSuccess_o`, out, EP_COUNT: qualifies Done; 1 = commit popped bytes, 0 = roll back.
- `out_valid_o`, out, 1: stream byte valid.
- `out_ready_i`, in, 1: downstream accepts the byte.
- `out_data_o`, out, 8: stream byte.
- `out_last_o`, out, 1: final byte of the current grant.
- `out_epIdx_o`, out, EP_IDX_WID: granted endpoint index; stable for the whole grant.
- `abort_i`, in, 1: downstream rejects the current grant and requests rollback.

## Operation
- **Reset values:** `state=IDLE`, `lastGrant=EP_COUNT-1` (so EP01 has first priority), byte counter 0, hold register 0, all outputs 0.
- **IDLE:**
  - If any `EP_IN_dataAvailable_i` is set, grant the first set index searching `lastGrant+1`, `lastGrant+2`, … with wrap modulo EP_COUNT.
  - Register the grant in `out_epIdx_o` and go to FETCH.
- **FETCH (1 cycle):**
  - Assert `popData[grant]`, load `EP_IN_data_i[grant]` into the hold register, set counter to 1, go to PRESENT.
  - If `dataAvailable[grant]` has dropped, go to DONE with success=1 and no byte streamed.
- **PRESENT:**
  - Drive `out_valid_o=1` and `out_data_o=hold`.
  - `out_last_o = !dataAvailable[grant] || counter==MAX_PKT_BYTES`.
  - Handshake occurs when `out_ready_i` is high:
    - If not last: assert `popData[grant]` in the same cycle, reload hold, increment counter, stay in PRESENT.
    - If last: go to DONE.
- **DONE (1 cycle):**
  - Pulse `EP_IN_popTransDone_o[grant]` with `EP_IN_popTransSuccess_o[grant] = !abortSeen`.
  - Set `lastGrant=grant`, clear `abortSeen` and counter, go to IDLE.
- **Abort:** `abort_i` high in FETCH or PRESENT sets `abortSeen` and goes to DONE next edge. No pop that cycle, `out_valid_o=0` from the next cycle. `abort_i` is ignored in IDLE and DONE.
- Abort takes priority over a simultaneous handshake: the byte counts as not accepted and no pop is issued.
- **MAX_PKT_BYTES truncation:** bytes beyond the limit stay in the FIFO and are committed as a new transaction on a later grant.
- **Single-endpoint outputs:** at most one bit of each `EP_IN_*_o` vector is set in any cycle, and only the granted bit.
- Zero-length packets are never signalled by the FIFO and are not streamed.
- **Reset mid-grant:** all outputs drop immediately and no Done is issued; the endpoint FIFO is reset by the same reset.

## Timing
- `dataAvailable` seen in IDLE → first `out_valid_o` 2 cycles later (IDLE→FETCH→PRESENT).
- With `out_ready_i` held high: 1 byte/cycle throughout PRESENT.
- Last handshake → Done pulse on the next cycle → IDLE → next grant. Back-to-back packets have 3 bubble cycles.
- While `out_valid_o` is high and no abort occurs, `out_data_o`, `out_last_o` and `out_epIdx_o` hold stable until the handshake (valid never drops without a handshake).
- `out_last_o` is combinational from `dataAvailable[grant]`. The FIFO must not change `dataAvailable` except in response to pops.

## Test plan
- **Single packet:** EP_COUNT=2, EP01 holds 3 bytes A1 A2 A3, ready=1 → stream A1,A2,A3 on idx 0 with last only on A3. Then `popTransDone[0]=1` and `popTransSuccess[0]=1` one cycle after A3; total 6 cycles from request.
- **Round-robin:** EP01 and EP02 each hold 1 packet, both available at once → EP01 served first, then EP02. With EP01 refilled, the next order is EP01 after EP02 (no starvation).
- **Backpressure:** 4-byte packet with ready toggling 1,0,0,1,1,0,1 → bytes stable while ready=0, exactly 4 pops, last on the 4th byte.
- **Abort:** `abort_i` asserted on the 2nd byte of a 5-byte packet → valid drops, Done with Success=0. The re-grant streams the same 5 bytes from byte 1.
- **Truncation:** MAX_PKT_BYTES=4 with 6 bytes queued → first grant streams 4 bytes with last on byte 4 and Success=1; second grant streams bytes 5–6.
- **Reset:** `rstn_i` low mid-PRESENT → all outputs 0 asynchronously. After release, arbitration starts with EP01 priority.

Source files
------------

// File: rtl/usb_ep_rx_drain_arbiter.sv
// -----------------------------------------------------------------------------
// usb_ep_rx_drain_arbiter
//
// Drains received host-OUT packets from the per-endpoint device-IN FIFOs
// (EP01..EPn) into one shared byte stream. One endpoint is granted at a time
// in round-robin order. The granted endpoint's transaction, capped at
// MAX_PKT_BYTES, is streamed with its endpoint index and a last-byte flag.
// The transaction is then committed to the FIFO, or rolled back if
// downstream aborted it.
//
// Ports
//   clk12_i                  12 MHz clock, all state on the rising edge
//   rstn_i                   asynchronous active-low reset
//   EP_IN_dataAvailable_i    per-endpoint "committed byte at head"
//   EP_IN_data_i             per-endpoint head byte, [k*8 +: 8], FWFT
//   EP_IN_popData_o          pop head byte of endpoint k
//   EP_IN_popTransDone_o     1-cycle pulse ending the read transaction
//   EP_IN_popTransSuccess_o  qualifies Done: 1 = commit, 0 = roll back
//   out_valid_o/out_ready_i  stream handshake
//   out_data_o               stream byte
//   out_last_o               final byte of the current grant
//   out_epIdx_o              granted endpoint index, stable for the grant
//   abort_i                  downstream rejects the current grant
//   dbg_state_o              current FSM state (IDLE=0 FETCH=1 PRESENT=2 DONE=3)
//
// Stream handshake: a byte transfers on a rising edge where
// out_valid_o && out_ready_i && !abort_i. Once out_valid_o rises,
// out_data_o, out_last_o and out_epIdx_o hold until that transfer or an
// abort; valid never drops without one of the two.
// -----------------------------------------------------------------------------
module usb_ep_rx_drain_arbiter #(
  parameter int EP_COUNT      = 2,
  parameter int MAX_PKT_BYTES = 64,
  localparam int EP_IDX_WID   = (EP_COUNT > 1) ? $clog2(EP_COUNT) : 1
) (
  input  logic                    clk12_i,
  input  logic                    rstn_i,
  input  logic [EP_COUNT-1:0]     EP_IN_dataAvailable_i,
  input  logic [8*EP_COUNT-1:0]   EP_IN_data_i,
  output logic [EP_COUNT-1:0]     EP_IN_popData_o,
  output logic [EP_COUNT-1:0]     EP_IN_popTransDone_o,
  output logic [EP_COUNT-1:0]     EP_IN_popTransSuccess_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [7:0]              out_data_o,
  output logic                    out_last_o,
  output logic [EP_IDX_WID-1:0]   out_epIdx_o,
  input  logic                    abort_i,
  output logic [1:0]              dbg_state_o
);

  localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e                state_q;
  logic [EP_IDX_WID-1:0] grant_q;
  logic [EP_IDX_WID-1:0] last_grant_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [7:0]            hold_q;
  logic                  abort_seen_q;

  logic                  avail_g;
  logic [7:0]            data_g;
  logic [EP_COUNT-1:0]   grant_oh;
  logic                  rr_found_d;
  logic [EP_IDX_WID-1:0] rr_pick_d;
  logic                  is_last;
  logic                  pop_c;

  // Head state of the granted endpoint, plus its one-hot select.
  always_comb begin
    avail_g  = 1'b0;
    data_g   = 8'h00;
    grant_oh = '0;
    for (int k = 0; k < EP_COUNT; k++) begin
      if (grant_q == EP_IDX_WID'(k)) begin
        avail_g     = EP_IN_dataAvailable_i[k];
        data_g      = EP_IN_data_i[k*8 +: 8];
        grant_oh[k] = 1'b1;
      end
    end
  end

  // Round-robin pick: lowest ready index above last_grant_q wins. If none
  // exists, wrap to the lowest ready index at or below it. Both loops run
  // downward so the lowest index is the one left standing. The second loop
  // overrides the first.
  always_comb begin
    rr_found_d = 1'b0;
    rr_pick_d  = '0;
    for (int k = EP_COUNT - 1; k >= 0; k--) begin
      if (EP_IN_dataAvailable_i[k] && (EP_IDX_WID'(k) <= last_grant_q)) begin
        rr_found_d = 1'b1;
        rr_pick_d  = EP_IDX_WID'(k);
      end
    end
    for (int k = EP_COUNT - 1; k >= 0; k--) begin
      if (EP_IN_dataAvailable_i[k] && (EP_IDX_WID'(k) > last_grant_q)) begin
        rr_found_d = 1'b1;
        rr_pick_d  = EP_IDX_WID'(k);
      end
    end
  end

  // The FIFO is first-word fall-through. While a byte is being presented,
  // dataAvailable therefore already reflects whether another byte follows
  // it.
  assign is_last = !avail_g || (cnt_q == CNT_W'(MAX_PKT_BYTES));

  // Pops happen in two cases: the FETCH cycle, and every non-final
  // accepted byte. The non-final pop pulls the next byte into the hold
  // register on the same edge. An abort in the same cycle suppresses the
  // pop.
  assign pop_c = !abort_i &&
                 (((state_q == ST_FETCH) && avail_g) ||
                  ((state_q == ST_PRESENT) && out_ready_i && !is_last));

  always_ff @(posedge clk12_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= EP_IDX_WID'(EP_COUNT - 1);
      cnt_q        <= '0;
      hold_q       <= 8'h00;
      abort_seen_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rr_found_d) begin
            grant_q <= rr_pick_d;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (abort_i) begin
            abort_seen_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (!avail_g) begin
            // Head vanished: close an empty transaction as a success.
            state_q <= ST_DONE;
          end else begin
            hold_q  <= data_g;
            cnt_q   <= CNT_W'(1);
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (abort_i) begin
            abort_seen_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (out_ready_i) begin
            if (is_last) begin
              state_q <= ST_DONE;
            end else begin
              hold_q <= data_g;
              cnt_q  <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          last_grant_q <= grant_q;
          abort_seen_q <= 1'b0;
          cnt_q        <= '0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Every output is a decode of registered state. The exceptions are pop
  // and last, which must react within the cycle to ready/abort and to the
  // FIFO head.
  assign out_valid_o             = (state_q == ST_PRESENT);
  assign out_data_o              = hold_q;
  assign out_last_o              = (state_q == ST_PRESENT) && is_last;
  assign out_epIdx_o             = grant_q;
  assign EP_IN_popData_o         = pop_c ? grant_oh : '0;
  assign EP_IN_popTransDone_o    = (state_q == ST_DONE) ? grant_oh : '0;
  assign EP_IN_popTransSuccess_o = ((state_q == ST_DONE) && !abort_seen_q) ? grant_oh : '0;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_usb_ep_rx_drain_arbiter.sv
module tb_usb_ep_rx_drain_arbiter;

  localparam int EP_N  = 2;
  localparam int MAXB  = 4;
  localparam int MEM_D = 1024;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [EP_N-1:0]   avail;
  logic [8*EP_N-1:0] fdata;
  logic [EP_N-1:0]   pop, done, succ;
  logic              valid, ready, last, abort;
  logic [7:0]        odata;
  logic [0:0]        idx;
  logic [1:0]        dbg;

  usb_ep_rx_drain_arbiter #(.EP_COUNT(EP_N), .MAX_PKT_BYTES(MAXB)) dut (
    .clk12_i                 (clk),
    .rstn_i                  (rstn),
    .EP_IN_dataAvailable_i   (avail),
    .EP_IN_data_i            (fdata),
    .EP_IN_popData_o         (pop),
    .EP_IN_popTransDone_o    (done),
    .EP_IN_popTransSuccess_o (succ),
    .out_valid_o             (valid),
    .out_ready_i             (ready),
    .out_data_o              (odata),
    .out_last_o              (last),
    .out_epIdx_o             (idx),
    .abort_i                 (abort),
    .dbg_state_o             (dbg)
  );

  // Endpoint FIFO environment. wr_p marks committed bytes, rd_p the
  // speculative read head, and cm_p the last committed read position.
  logic [7:0] mem [EP_N][MEM_D];
  int wr_p [EP_N];
  int rd_p [EP_N];
  int cm_p [EP_N];

  always_comb begin
    for (int k = 0; k < EP_N; k++) begin
      avail[k]        = (rd_p[k] != wr_p[k]);
      fdata[k*8 +: 8] = mem[k][10'(rd_p[k])];
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < EP_N; k++) begin
        rd_p[k] <= wr_p[k];
        cm_p[k] <= wr_p[k];
      end
    end else begin
      for (int k = 0; k < EP_N; k++) begin
        if (pop[k]) rd_p[k] <= rd_p[k] + 1;
        if (done[k]) begin
          if (succ[k]) cm_p[k] <= rd_p[k];
          else         rd_p[k] <= cm_p[k];
        end
      end
    end
  end

  // bookkeeping
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Driver tasks start and end exactly at a falling edge.
  task automatic push_bytes(input int ep, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) mem[ep][10'(wr_p[ep] + i)] = base + 8'(i);
    wr_p[ep] = wr_p[ep] + n;
  endtask

  // Directed per-cycle vectors
  typedef struct {
    int         sect;
    logic       ready;
    logic       abort;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [1:0] pop;
    logic [1:0] done;
    logic [1:0] succ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int s, input logic r, input logic a, input logic v,
                              input logic [7:0] d, input logic l, input logic [1:0] p,
                              input logic [1:0] dn, input logic [1:0] sc);
    vec_t t;
    t.sect = s; t.ready = r; t.abort = a; t.valid = v; t.data = d; t.last = l;
    t.pop = p; t.done = dn; t.succ = sc;
    return t;
  endfunction

  task automatic apply_sect(input int s, input string name);
    int row;
    row = 0;
    foreach (tbl[i]) begin
      if (tbl[i].sect == s) begin
        ready = tbl[i].ready;
        abort = tbl[i].abort;
        #1;
        chk($sformatf("%s[%0d].valid", name, row), 32'(valid), 32'(tbl[i].valid));
        if (tbl[i].valid) begin
          chk($sformatf("%s[%0d].data", name, row), 32'(odata), 32'(tbl[i].data));
          chk($sformatf("%s[%0d].last", name, row), 32'(last), 32'(tbl[i].last));
          chk($sformatf("%s[%0d].idx", name, row), 32'(idx), 32'(0));
        end
        chk($sformatf("%s[%0d].pop", name, row), 32'(pop), 32'(tbl[i].pop));
        chk($sformatf("%s[%0d].done", name, row), 32'(done), 32'(tbl[i].done));
        chk($sformatf("%s[%0d].succ", name, row), 32'(succ), 32'(tbl[i].succ));
        row++;
        @(negedge clk);
      end
    end
    abort = 1'b0;
  endtask

  // Stream scoreboard: {idx, last, data} per accepted byte and
  // {done, succ} per Done pulse.
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [3:0] exp_dn_q[$];
  logic [3:0] got_dn_q[$];

  function automatic logic [9:0] sb(input logic i, input logic l, input logic [7:0] d);
    return {i, l, d};
  endfunction

  // mode: 0 = ready low, 1 = ready high, 2 = random ready
  task automatic collect(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      ready = (mode == 2) ? 1'($urandom_range(0, 1)) : ((mode == 1) ? 1'b1 : 1'b0);
      abort = 1'b0;
      #1;
      if (valid && ready) got_q.push_back({idx, last, odata});
      if (done != 2'b00) got_dn_q.push_back({done, succ});
      @(negedge clk);
    end
  endtask

  task automatic check_streams(input string name);
    chk({name, ".bytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s.b%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({name, ".dones"}, 32'(got_dn_q.size()), 32'(exp_dn_q.size()));
    for (int i = 0; i < exp_dn_q.size() && i < got_dn_q.size(); i++)
      chk($sformatf("%s.d%0d", name, i), 32'(got_dn_q[i]), 32'(exp_dn_q[i]));
    exp_q.delete(); got_q.delete(); exp_dn_q.delete(); got_dn_q.delete();
  endtask

  // Transaction-level reference for the random phase. Each endpoint holds
  // a queue of committed, unconsumed bytes. A grant takes the round-robin
  // choice among non-empty queues and carries min(size, MAXB) bytes. The
  // first byte appears two cycles after the grant decision and Done
  // follows the final transfer or the abort.
  logic [7:0] mq [EP_N][$];
  int  last_g, cur, txn_len, sent;
  bit  busy, in_fetch, done_due, aborted;

  task automatic run_random(input int n);
    logic       exp_valid, exp_last;
    logic [1:0] exp_pop;
    int         k, len;
    logic [7:0] base;
    bit         found;
    for (int c = 0; c < n; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, EP_N - 1);
        if (!(busy && cur == k) && mq[k].size() < 100) begin
          len  = $urandom_range(1, 6);
          base = 8'($urandom);
          push_bytes(k, len, base);
          for (int j = 0; j < len; j++) mq[k].push_back(base + 8'(j));
        end
      end
      #1;
      exp_valid = busy && !in_fetch && !done_due;
      exp_last  = 1'b0;
      chk("rnd.valid", 32'(valid), 32'(exp_valid));
      if (exp_valid) begin
        exp_last = (sent + 1 == txn_len);
        chk("rnd.idx", 32'(idx), 32'(cur));
        chk("rnd.data", 32'(odata), 32'(mq[cur][sent]));
        chk("rnd.last", 32'(last), 32'(exp_last));
      end
      exp_pop = 2'b00;
      if (busy && in_fetch && !abort) exp_pop = 2'(1 << cur);
      if (exp_valid && ready && !abort && !exp_last) exp_pop = 2'(1 << cur);
      chk("rnd.pop", 32'(pop), 32'(exp_pop));
      chk("rnd.done", 32'(done), done_due ? 32'(1 << cur) : 32'(0));
      chk("rnd.succ", 32'(succ), (done_due && !aborted) ? 32'(1 << cur) : 32'(0));
      // advance the reference across the coming edge
      if (done_due) begin
        if (!aborted) repeat (txn_len) void'(mq[cur].pop_front());
        last_g   = cur;
        busy     = 1'b0;
        done_due = 1'b0;
      end else if (busy && in_fetch) begin
        in_fetch = 1'b0;
        if (abort) begin aborted = 1'b1; done_due = 1'b1; end
      end else if (exp_valid) begin
        if (abort) begin
          aborted = 1'b1; done_due = 1'b1;
        end else if (ready) begin
          sent++;
          if (sent == txn_len) done_due = 1'b1;
        end
      end else if (!busy) begin
        found = 1'b0;
        for (int i = 1; i <= EP_N; i++) begin
          k = (last_g + i) % EP_N;
          if (!found && mq[k].size() > 0) begin
            found = 1'b1; cur = k;
          end
        end
        if (found) begin
          busy     = 1'b1;
          in_fetch = 1'b1;
          aborted  = 1'b0;
          sent     = 0;
          txn_len  = (mq[cur].size() < MAXB) ? mq[cur].size() : MAXB;
        end
      end
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  initial begin
    // vector tables
    // 1: single 3-byte packet A1 A2 A3 on EP01, ready high
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(1, 1, 0, 1, 8'hA1, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(1, 1, 0, 1, 8'hA2, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(1, 1, 0, 1, 8'hA3, 1, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 0, 2'b00, 2'b01, 2'b01));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 2'b00));
    // 2: 4-byte packet, ready 1,0,0,1,1,0,1 while presenting
    tbl.push_back(mk(2, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2, 0, 0, 0, 8'h00, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2, 1, 0, 1, 8'hB1, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2, 0, 0, 1, 8'hB2, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2, 0, 0, 1, 8'hB2, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2, 1, 0, 1, 8'hB2, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2, 1, 0, 1, 8'hB3, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2, 0, 0, 1, 8'hB4, 1, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2, 1, 0, 1, 8'hB4, 1, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2, 0, 0, 0, 8'h00, 0, 2'b00, 2'b01, 2'b01));
    // 3: abort on the 2nd byte of a 5-byte packet; abort in IDLE/DONE ignored
    tbl.push_back(mk(3, 1, 1, 0, 8'h00, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(3, 1, 0, 0, 8'h00, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(3, 1, 0, 1, 8'hE1, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(3, 1, 1, 1, 8'hE2, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(3, 1, 1, 0, 8'h00, 0, 2'b00, 2'b01, 2'b00));

    foreach (mem[k, j]) mem[k][j] = 8'h00;
    rstn = 1'b0; ready = 1'b0; abort = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("reset.valid", 32'(valid), 32'(0));
    chk("reset.last", 32'(last), 32'(0));
    chk("reset.data", 32'(odata), 32'(0));
    chk("reset.idx", 32'(idx), 32'(0));
    chk("reset.pop", 32'(pop), 32'(0));
    chk("reset.done", 32'(done), 32'(0));
    chk("reset.succ", 32'(succ), 32'(0));
    chk("reset.state", 32'(dbg), 32'(0));
    @(negedge clk);
    rstn = 1'b1;

    // round robin: both endpoints ready, then EP01 refilled while EP02 waits
    push_bytes(0, 1, 8'hC1);
    push_bytes(1, 1, 8'hD1);
    collect(4, 1);
    push_bytes(0, 1, 8'hC2);
    collect(16, 1);
    exp_q.push_back(sb(0, 1, 8'hC1));
    exp_q.push_back(sb(1, 1, 8'hD1));
    exp_q.push_back(sb(0, 1, 8'hC2));
    exp_dn_q.push_back(4'b0101);
    exp_dn_q.push_back(4'b1010);
    exp_dn_q.push_back(4'b0101);
    check_streams("rr");

    push_bytes(0, 3, 8'hA1);
    apply_sect(1, "single");
    push_bytes(0, 4, 8'hB1);
    apply_sect(2, "bkpr");
    push_bytes(0, 5, 8'hE1);
    apply_sect(3, "abort");

    // re-grant after abort replays from E1, split at the 4-byte limit
    collect(40, 2);
    for (int i = 0; i < 5; i++) exp_q.push_back(sb(0, (i == 3 || i == 4), 8'hE1 + 8'(i)));
    exp_dn_q.push_back(4'b0101);
    exp_dn_q.push_back(4'b0101);
    check_streams("regrant");

    // truncation: 6 bytes -> 4 + 2
    push_bytes(0, 6, 8'hF1);
    collect(40, 2);
    for (int i = 0; i < 6; i++) exp_q.push_back(sb(0, (i == 3 || i == 5), 8'hF1 + 8'(i)));
    exp_dn_q.push_back(4'b0101);
    exp_dn_q.push_back(4'b0101);
    check_streams("trunc");

    // reset in the middle of PRESENT
    push_bytes(0, 4, 8'h91);
    collect(3, 0);
    #1;
    chk("rst.pre_valid", 32'(valid), 32'(1));
    #1;
    rstn = 1'b0;
    #1;
    chk("rst.valid", 32'(valid), 32'(0));
    chk("rst.last", 32'(last), 32'(0));
    chk("rst.data", 32'(odata), 32'(0));
    chk("rst.pop", 32'(pop), 32'(0));
    chk("rst.done", 32'(done), 32'(0));
    chk("rst.state", 32'(dbg), 32'(0));
    @(negedge clk);
    rstn = 1'b1;
    got_q.delete(); got_dn_q.delete();
    push_bytes(0, 1, 8'h55);
    push_bytes(1, 1, 8'h66);
    collect(16, 1);
    exp_q.push_back(sb(0, 1, 8'h55));
    exp_q.push_back(sb(1, 1, 8'h66));
    exp_dn_q.push_back(4'b0101);
    exp_dn_q.push_back(4'b1010);
    check_streams("after_rst");

    // random traffic against the reference
    last_g = 1; busy = 1'b0; in_fetch = 1'b0; done_due = 1'b0; aborted = 1'b0;
    cur = 0; sent = 0; txn_len = 0;
    run_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
